// File: rtl/mole_link_pkg.sv
// Shared constants, link state encoding and byte classification for the
// host side of the whack-a-mole serial link.
package mole_link_pkg;

    localparam logic [7:0] CMD_START  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_HIT    = 8'h48;  // 'H', also the hit-confirm event
    localparam logic [7:0] EVT_OVER   = 8'h52;  // 'R'
    localparam logic [7:0] EVT_DIGIT0 = 8'h30;  // '0'

    localparam int NUM_MOLES = 5;

    localparam logic [7:0] EVT_DIGIT_LAST = EVT_DIGIT0 + 8'(NUM_MOLES - 1);

    typedef enum logic [1:0] {
        LINK_IDLE    = 2'd0,
        LINK_ARMED   = 2'd1,
        LINK_PLAYING = 2'd2,
        LINK_OVER    = 2'd3
    } link_state_e;

    function automatic logic is_mole_digit(input logic [7:0] b);
        return (b >= EVT_DIGIT0) && (b <= EVT_DIGIT_LAST);
    endfunction

endpackage

// File: rtl/mole_link_if.sv
// UART-side byte handshake between the link host (master) and the
// uart_rx/uart_tx pair (slave).
interface mole_link_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  rx_data,
        input  rx_ready,
        input  tx_busy,
        output tx_start,
        output tx_data
    );

    modport slave (
        output rx_data,
        output rx_ready,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/mole_link_fifo.sv
// Synchronous 8-bit command FIFO with registered read data; the read word
// is held until the next pop so it can drive tx_data directly.
module mole_link_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  rd_data_q;
    logic        do_wr;
    logic        do_rd;

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mole_link_host.sv
// Host endpoint of the whack-a-mole link: decodes board events, tracks the
// game state, queues 'S'/'H' commands and paces them into uart_tx.
module mole_link_host
    import mole_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    mole_link_if.master link,
    input  logic        start_req,
    input  logic        click_valid,
    input  logic [2:0]  click_index,
    output logic [2:0]  mole_index,
    output logic        mole_valid,
    output logic [1:0]  link_state,
    output logic [7:0]  hit_count,
    output logic [7:0]  miss_count,
    output logic        link_timeout,
    output logic        proto_error
);
    localparam int             WDW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);

    link_state_e    state_q, state_d;
    logic [2:0]     mole_index_q, mole_index_d;
    logic           mole_valid_q, mole_valid_d;
    logic [7:0]     hit_q, hit_d;
    logic [7:0]     miss_q, miss_d;
    logic           timeout_q, timeout_d;
    logic           perr_q, perr_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           tx_start_q, tx_start_d;

    logic           rx_digit;
    logic           rx_hit;
    logic           enq_valid;
    logic [7:0]     enq_data;
    logic           fifo_full;
    logic           fifo_empty;

    mole_link_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (enq_valid),
        .wr_data_i (enq_data),
        .rd_en_i   (tx_start_d),
        .rd_data_o (link.tx_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign rx_digit = link.rx_ready && is_mole_digit(link.rx_data);
    assign rx_hit   = link.rx_ready && (link.rx_data == CMD_HIT);

    always_comb begin
        state_d      = state_q;
        mole_index_d = mole_index_q;
        mole_valid_d = mole_valid_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        timeout_d    = timeout_q;
        perr_d       = perr_q;
        wd_d         = wd_q;
        enq_valid    = 1'b0;
        enq_data     = CMD_START;

        if (link.rx_ready) begin
            if (rx_digit) begin
                mole_index_d = 3'(link.rx_data - EVT_DIGIT0);
                mole_valid_d = 1'b1;
                if (state_q == LINK_IDLE || state_q == LINK_ARMED) begin
                    state_d = LINK_PLAYING;
                end
            end else if (rx_hit) begin
                if (state_q == LINK_PLAYING && hit_q != 8'hFF) begin
                    hit_d = hit_q + 8'd1;
                end
            end else if (link.rx_data == EVT_OVER) begin
                if (state_q == LINK_PLAYING) begin
                    state_d      = LINK_OVER;
                    mole_valid_d = 1'b0;
                end
            end else begin
                perr_d = 1'b1;
            end
        end

        // Clicks judge against the mole shown before this cycle's RX update.
        if (click_valid && state_q == LINK_PLAYING && mole_valid_q) begin
            if (click_index == mole_index_q) begin
                enq_valid = 1'b1;
                enq_data  = CMD_HIT;
            end else if (miss_q != 8'hFF) begin
                miss_d = miss_q + 8'd1;
            end
        end

        if (start_req && (state_q == LINK_IDLE || state_q == LINK_OVER)) begin
            enq_valid = 1'b1;
            enq_data  = CMD_START;
            hit_d     = 8'd0;
            miss_d    = 8'd0;
            timeout_d = 1'b0;
            state_d   = LINK_ARMED;
        end

        if (enq_valid && fifo_full) begin
            perr_d = 1'b1;
        end

        if (state_q == LINK_PLAYING && state_d == LINK_PLAYING) begin
            if (rx_digit || rx_hit) begin
                wd_d = '0;
            end else if (wd_q != WD_LIMIT) begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end
        if (wd_d == WD_LIMIT) begin
            timeout_d = 1'b1;
        end

        // Skipping the cycle after a strobe covers uart_tx raising tx_busy.
        tx_start_d = !fifo_empty && !link.tx_busy && !tx_start_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LINK_IDLE;
            mole_index_q <= 3'd0;
            mole_valid_q <= 1'b0;
            hit_q        <= 8'd0;
            miss_q       <= 8'd0;
            timeout_q    <= 1'b0;
            perr_q       <= 1'b0;
            wd_q         <= '0;
            tx_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mole_index_q <= mole_index_d;
            mole_valid_q <= mole_valid_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            timeout_q    <= timeout_d;
            perr_q       <= perr_d;
            wd_q         <= wd_d;
            tx_start_q   <= tx_start_d;
        end
    end

    assign link.tx_start = tx_start_q;
    assign mole_index    = mole_index_q;
    assign mole_valid    = mole_valid_q;
    assign link_state    = state_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;
    assign link_timeout  = timeout_q;
    assign proto_error   = perr_q;

endmodule
